mor1kx_branch_resolve: RTL
==========================

MOR1KX_BRANCH_RESOLVE -- requirements
Module: mor1kx_branch_resolve

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32: PC/target width.
REQ-002 SHALL have parameter PERF_CNT_WIDTH, default 16: statistics counter width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have inputs padv_decode_i (1, decode advance), pipeline_flush_i (1, flush).
REQ-006 SHALL have inputs op_bf_i and op_bnf_i (1 each), decoded conditional branch type.
REQ-007 SHALL have input predicted_flag_i (1), the flag value predicted for the decoded branch.
REQ-008 SHALL have inputs decode_pc_i and branch_target_i (OPTION_OPERAND_WIDTH each), the branch PC and its taken target.
REQ-009 SHALL have inputs padv_execute_i (1, execute advance/resolve strobe) and flag_i (1, real SR[F]).
REQ-010 SHALL have input redirect_ack_i (1), fetch acceptance of the redirect.
REQ-011 SHALL have outputs prev_op_brcond_o and prev_predicted_flag_o (1 each), registered branch state to the predictor.
REQ-012 SHALL have outputs execute_bf_o and execute_bnf_o (1 each), registered branch type.
REQ-013 SHALL have outputs branch_mispredict_o (1, combinational), redirect_valid_o (1), redirect_pc_o (OPTION_OPERAND_WIDTH), stall_o (1).
REQ-014 SHALL have outputs branch_count_o and mispredict_count_o (PERF_CNT_WIDTH each), plus input cnt_clear_i (1).

Function
REQ-015 SHALL implement FSM states IDLE, HELD, REDIRECT.
REQ-016 IDLE: on padv_decode_i & (op_bf_i|op_bnf_i) & !stall_o, capture bf, bnf, predicted flag, target and fallthrough = decode_pc_i + 8 (delay slot skipped), modulo 2^OPTION_OPERAND_WIDTH; go HELD.
REQ-017 prev_op_brcond_o SHALL be 1 exactly while in HELD; prev_predicted_flag_o, execute_bf_o and execute_bnf_o SHALL reflect the captured values.
REQ-018 branch_mispredict_o SHALL equal prev_op_brcond_o & (flag_i != prev_predicted_flag_o).
REQ-019 HELD & padv_execute_i: resolve; real_taken = bf ? flag_i : !flag_i.
REQ-020 On resolve without mispredict: if a new branch is captured in the same cycle, stay HELD with the new contents; otherwise go IDLE.
REQ-021 On resolve with mispredict: go REDIRECT, registering redirect_pc_o = real_taken ? target : fallthrough, and ignoring any same-cycle decode capture.
REQ-022 REDIRECT: redirect_valid_o = 1 and redirect_pc_o SHALL remain stable until redirect_ack_i; on ack, go IDLE the next cycle.
REQ-023 stall_o SHALL be 1 in REDIRECT, and in HELD when !padv_execute_i; it SHALL be 0 otherwise.
REQ-024 While stall_o = 1, decode branches SHALL NOT be captured.
REQ-025 pipeline_flush_i SHALL force IDLE, clearing captured state, redirect_valid_o and any pending redirect, with priority over capture, resolve and ack.
REQ-026 A flush in HELD SHALL NOT count the branch.
REQ-027 branch_count_o SHALL increment on every resolve, and mispredict_count_o on every mispredicting resolve; both saturate at all-ones without wrap.
REQ-028 cnt_clear_i SHALL zero both counters, with priority over a same-cycle increment.
REQ-029 Outside HELD, branch_mispredict_o SHALL be 0 regardless of flag_i.

Reset
REQ-030 On rst assertion, all state SHALL clear asynchronously: FSM = IDLE, every registered output = 0, redirect_pc_o = 0, counters = 0.
REQ-031 Reset mid-REDIRECT SHALL drop redirect_valid_o immediately, without waiting for ack.
REQ-032 After rst deassertion, capture SHALL be possible on the first clock edge.

Verification
REQ-033 Scenario: bf at pc 0x100, target 0x200, predicted 1, flag_i=1 on resolve -> no mispredict, branch_count=1, mispredict_count=0, redirect_valid_o stays 0.
REQ-034 Scenario: bnf at pc 0x100, target 0x200, predicted 1, flag_i=0 -> branch_mispredict_o=1 in the resolve cycle; next cycle redirect_valid_o=1 with redirect_pc_o=0x200; held 3 cycles until ack; then IDLE.
REQ-035 Scenario: bf at pc 0x100, predicted 1, flag_i=0 -> redirect_pc_o=0x108; a new branch offered during REDIRECT is not captured and stall_o=1.
REQ-036 Scenario: back-to-back correctly predicted branches with padv_decode_i=padv_execute_i=1 each cycle -> state stays HELD and branch_count advances 1 per cycle.
REQ-037 Scenario: pipeline_flush_i in REDIRECT, same cycle as ack -> IDLE next cycle, redirect_valid_o=0, counters unchanged.
REQ-038 Scenario: PERF_CNT_WIDTH=4, 17 mispredicts -> both counters read 0xF; cnt_clear_i coincident with a resolve -> both read 0.

Source files
------------

// File: rtl/mor1kx_branch_resolve.sv
// Conditional-branch resolution: holds one predicted branch from decode until execute
// resolves it, raises a fetch redirect on mispredict and keeps branch statistics.
module mor1kx_branch_resolve #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int PERF_CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            pipeline_flush_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] branch_target_i,
  input  logic                            padv_execute_i,
  input  logic                            flag_i,
  input  logic                            redirect_ack_i,
  input  logic                            cnt_clear_i,
  output logic                            prev_op_brcond_o,
  output logic                            prev_predicted_flag_o,
  output logic                            execute_bf_o,
  output logic                            execute_bnf_o,
  output logic                            branch_mispredict_o,
  output logic                            redirect_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            stall_o,
  output logic [PERF_CNT_WIDTH-1:0]       branch_count_o,
  output logic [PERF_CNT_WIDTH-1:0]       mispredict_count_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HELD     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam logic [PERF_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]                      state_reg, state_next;
  logic                            bf_reg, bnf_reg, pred_reg;
  logic [OPTION_OPERAND_WIDTH-1:0] target_reg, fall_reg, redirect_pc_reg;
  logic [PERF_CNT_WIDTH-1:0]       branch_cnt_reg, mispredict_cnt_reg;

  logic held, resolve, mispredict, capture, real_taken;

  assign held       = (state_reg == HELD);
  assign stall_o    = (state_reg == REDIRECT) | (held & !padv_execute_i);
  assign mispredict = held & (flag_i != pred_reg);
  assign resolve    = held & padv_execute_i;
  assign capture    = padv_decode_i & (op_bf_i | op_bnf_i) & !stall_o;
  assign real_taken = bf_reg ? flag_i : !flag_i;

  assign prev_op_brcond_o      = held;
  assign prev_predicted_flag_o = pred_reg;
  assign execute_bf_o          = bf_reg;
  assign execute_bnf_o         = bnf_reg;
  assign branch_mispredict_o   = mispredict;
  assign redirect_valid_o      = (state_reg == REDIRECT);
  assign redirect_pc_o         = redirect_pc_reg;
  assign branch_count_o        = branch_cnt_reg;
  assign mispredict_count_o    = mispredict_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (capture) state_next = HELD;
      HELD: begin
        if (resolve) begin
          if (mispredict)   state_next = REDIRECT;
          else if (capture) state_next = HELD;
          else              state_next = IDLE;
        end
      end
      REDIRECT: if (redirect_ack_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (pipeline_flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      bf_reg          <= 1'b0;
      bnf_reg         <= 1'b0;
      pred_reg        <= 1'b0;
      target_reg      <= '0;
      fall_reg        <= '0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pipeline_flush_i) begin
        bf_reg          <= 1'b0;
        bnf_reg         <= 1'b0;
        pred_reg        <= 1'b0;
        target_reg      <= '0;
        fall_reg        <= '0;
        redirect_pc_reg <= '0;
      end else begin
        // A mispredicting resolve squashes whatever decode offers in the same cycle.
        if (capture && !(resolve && mispredict)) begin
          bf_reg     <= op_bf_i;
          bnf_reg    <= op_bnf_i;
          pred_reg   <= predicted_flag_i;
          target_reg <= branch_target_i;
          fall_reg   <= decode_pc_i + OPTION_OPERAND_WIDTH'(8);
        end
        if (resolve && mispredict)
          redirect_pc_reg <= real_taken ? target_reg : fall_reg;
      end
    end
  end

  // Counters saturate; a flush discards the resolve so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (cnt_clear_i) begin
      branch_cnt_reg     <= '0;
      mispredict_cnt_reg <= '0;
    end else if (resolve && !pipeline_flush_i) begin
      if (branch_cnt_reg != CNT_MAX)
        branch_cnt_reg <= branch_cnt_reg + 1'b1;
      if (mispredict && (mispredict_cnt_reg != CNT_MAX))
        mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
    end
  end

endmodule
